butterfly_pipe_multi: RTL and testbench

// - Next-generation radix-2 butterfly for the FFT datapath: b parallel lanes per transaction.

---
 rtl/butterfly_pipe_multi.sv | 192 +++++++++++++++++++
 tb/tb_butterfly_pipe_multi.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/butterfly_pipe_multi.sv
// butterfly_pipe_multi: radix-2 FFT butterfly, b parallel lanes, 3-stage stall-able pipeline.
// Each lane computes c = a + w*b and d = a - w*b in Q(n-d).d fixed point.
// Per-transaction modes: scale (arith >>1 of results), inv (use conj(w)).
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   recv_val / recv_rdy   input handshake
//   ar, ac, br, bc        operands a, b (real/imag), lane i at [i*n +: n]
//   wr, wc                twiddle (real/imag)
//   scale, inv            mode bits, sampled with the inputs
//   send_val / send_rdy   output handshake
//   cr, cc, dr, dc        results a+w*b, a-w*b (real/imag)
//   ovf                   (BUTTERFLY_SAT_EN only) any clamp event in this transaction
//
// Build option: define BUTTERFLY_SAT_EN to clamp instead of wrap and add the ovf port.
// Timing is identical in both builds.
module butterfly_pipe_multi #(
    parameter int n = 32,
    parameter int d = 16,
    parameter int b = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           recv_val,
    output logic           recv_rdy,
    input  logic [n*b-1:0] ar,
    input  logic [n*b-1:0] ac,
    input  logic [n*b-1:0] br,
    input  logic [n*b-1:0] bc,
    input  logic [n*b-1:0] wr,
    input  logic [n*b-1:0] wc,
    input  logic           scale,
    input  logic           inv,
    output logic           send_val,
    input  logic           send_rdy,
    output logic [n*b-1:0] cr,
    output logic [n*b-1:0] cc,
    output logic [n*b-1:0] dr,
    output logic [n*b-1:0] dc
`ifdef BUTTERFLY_SAT_EN
    ,
    output logic           ovf
`endif
);

    // Wide enough to hold the difference of two full 2n-bit products exactly.
    localparam int PW = 2 * n + 1;

    function automatic logic signed [2*n-1:0] mul(input logic [n-1:0] x, input logic [n-1:0] y);
        return $signed({{n{x[n-1]}}, x}) * $signed({{n{y[n-1]}}, y});
    endfunction

    // Reduce a wide signed value to n bits: wrap, or clamp when saturation is built in.
    function automatic logic [n-1:0] fit(input logic signed [PW-1:0] x);
`ifdef BUTTERFLY_SAT_EN
        if ((&x[PW-1:n-1]) | ~(|x[PW-1:n-1])) return x[n-1:0];
        return x[PW-1] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
`else
        return x[n-1:0];
`endif
    endfunction

`ifdef BUTTERFLY_SAT_EN
    function automatic logic clip(input logic signed [PW-1:0] x);
        return ~((&x[PW-1:n-1]) | ~(|x[PW-1:n-1]));
    endfunction
`endif

    logic advance;
    assign advance  = ~send_val | send_rdy;
    assign recv_rdy = advance & ~reset;

    // Stage 1: operand a, scale bit and four partial products per lane (inv already applied).
    logic                  v1, scale1;
    logic signed [n-1:0]   a_r1 [b];
    logic signed [n-1:0]   a_c1 [b];
    logic signed [2*n-1:0] p_rr1 [b];  // br*wr
    logic signed [2*n-1:0] p_ii1 [b];  // bc*wc'
    logic signed [2*n-1:0] p_ri1 [b];  // br*wc'
    logic signed [2*n-1:0] p_ir1 [b];  // bc*wr

    // Stage 2: a and t = w*b truncated to n bits.
    logic                v2, scale2;
    logic signed [n-1:0] a_r2 [b];
    logic signed [n-1:0] a_c2 [b];
    logic signed [n-1:0] t_r2 [b];
    logic signed [n-1:0] t_c2 [b];
    logic [n-1:0]        t_r_n [b];
    logic [n-1:0]        t_c_n [b];

    // Stage 3 next values.
    logic [n*b-1:0] cr_n, cc_n, dr_n, dc_n;

`ifdef BUTTERFLY_SAT_EN
    logic ovf2, ovf2_n, ovf3_n;
`endif

    always_comb begin
        logic signed [PW-1:0] sr, sc;
`ifdef BUTTERFLY_SAT_EN
        ovf2_n = 1'b0;
`endif
        for (int i = 0; i < b; i++) begin
            sr = PW'(p_rr1[i]) - PW'(p_ii1[i]);
            sc = PW'(p_ri1[i]) + PW'(p_ir1[i]);
            sr = sr >>> d;
            sc = sc >>> d;
            t_r_n[i] = fit(sr);
            t_c_n[i] = fit(sc);
`ifdef BUTTERFLY_SAT_EN
            ovf2_n = ovf2_n | clip(sr) | clip(sc);
`endif
        end
    end

    always_comb begin
        logic signed [n:0] s_cr, s_cc, s_dr, s_dc;
        cr_n = '0;
        cc_n = '0;
        dr_n = '0;
        dc_n = '0;
`ifdef BUTTERFLY_SAT_EN
        ovf3_n = 1'b0;
`endif
        for (int i = 0; i < b; i++) begin
            s_cr = (n+1)'(a_r2[i]) + (n+1)'(t_r2[i]);
            s_cc = (n+1)'(a_c2[i]) + (n+1)'(t_c2[i]);
            s_dr = (n+1)'(a_r2[i]) - (n+1)'(t_r2[i]);
            s_dc = (n+1)'(a_c2[i]) - (n+1)'(t_c2[i]);
            // Halving an n+1-bit sum always fits in n bits, so only scale=0 can clamp.
            cr_n[i*n +: n] = scale2 ? s_cr[n:1] : fit(PW'(s_cr));
            cc_n[i*n +: n] = scale2 ? s_cc[n:1] : fit(PW'(s_cc));
            dr_n[i*n +: n] = scale2 ? s_dr[n:1] : fit(PW'(s_dr));
            dc_n[i*n +: n] = scale2 ? s_dc[n:1] : fit(PW'(s_dc));
`ifdef BUTTERFLY_SAT_EN
            ovf3_n = ovf3_n | (~scale2 & (clip(PW'(s_cr)) | clip(PW'(s_cc)) |
                                          clip(PW'(s_dr)) | clip(PW'(s_dc))));
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            send_val <= 1'b0;
            cr       <= '0;
            cc       <= '0;
            dr       <= '0;
            dc       <= '0;
`ifdef BUTTERFLY_SAT_EN
            ovf2     <= 1'b0;
            ovf      <= 1'b0;
`endif
        end else if (advance) begin
            v1       <= recv_val;
            v2       <= v1;
            send_val <= v2;
            scale1   <= scale;
            scale2   <= scale1;
            for (int i = 0; i < b; i++) begin
                a_r1[i]  <= ar[i*n +: n];
                a_c1[i]  <= ac[i*n +: n];
                p_rr1[i] <= mul(br[i*n +: n], wr[i*n +: n]);
                p_ir1[i] <= mul(bc[i*n +: n], wr[i*n +: n]);
                // Conjugate by negating the full-width products, which cannot overflow.
                p_ii1[i] <= inv ? -mul(bc[i*n +: n], wc[i*n +: n])
                                :  mul(bc[i*n +: n], wc[i*n +: n]);
                p_ri1[i] <= inv ? -mul(br[i*n +: n], wc[i*n +: n])
                                :  mul(br[i*n +: n], wc[i*n +: n]);
                a_r2[i]  <= a_r1[i];
                a_c2[i]  <= a_c1[i];
                t_r2[i]  <= t_r_n[i];
                t_c2[i]  <= t_c_n[i];
            end
`ifdef BUTTERFLY_SAT_EN
            ovf2 <= ovf2_n;
`endif
            // Keep the last result on the outputs across bubbles.
            if (v2) begin
                cr <= cr_n;
                cc <= cc_n;
                dr <= dr_n;
                dc <= dc_n;
`ifdef BUTTERFLY_SAT_EN
                ovf <= ovf2 | ovf3_n;
`endif
            end
        end
    end

endmodule

// File: tb/tb_butterfly_pipe_multi.sv
module tb_butterfly_pipe_multi;

    localparam int N  = 32;
    localparam int B  = 4;
    localparam int VW = N * B;

    logic          clk = 1'b0;
    logic          reset;
    logic          recv_val, recv_rdy;
    logic [VW-1:0] ar, ac, br, bc, wr, wc;
    logic          scale, inv;
    logic          send_val;
    logic          send_rdy;
    logic [VW-1:0] cr, cc, dr, dc;

    butterfly_pipe_multi #(.n(N), .d(16), .b(B)) dut (
        .clk      (clk),
        .reset    (reset),
        .recv_val (recv_val),
        .recv_rdy (recv_rdy),
        .ar       (ar),
        .ac       (ac),
        .br       (br),
        .bc       (bc),
        .wr       (wr),
        .wc       (wc),
        .scale    (scale),
        .inv      (inv),
        .send_val (send_val),
        .send_rdy (send_rdy),
        .cr       (cr),
        .cc       (cc),
        .dr       (dr),
        .dc       (dc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0] c_r, c_c, d_r, d_c;
        int            acc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   lat_on = 1'b0;
    int   rdy_mode = 0;   // 0: ready unless stalling, 1: random
    int   stall_cnt = 0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) send_rdy = 1'($urandom_range(0, 1));
        else if (stall_cnt > 0) begin
            send_rdy = 1'b0;
            stall_cnt--;
        end else send_rdy = 1'b1;
    end

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on one lane.
    task automatic lane_model(input logic [31:0] a_r, a_c, b_r, b_c, w_r, w_c,
                              input bit sc, iv,
                              output logic [31:0] c_r, c_c, d_r, d_c);
        longint wci, tr, tc, s;
        logic signed [64:0] xr, xc;
        wci = iv ? -longint'($signed(w_c)) : longint'($signed(w_c));
        xr = 65'(longint'($signed(b_r)) * longint'($signed(w_r))) - 65'(longint'($signed(b_c)) * wci);
        xc = 65'(longint'($signed(b_r)) * wci) + 65'(longint'($signed(b_c)) * longint'($signed(w_r)));
        xr = xr >>> 16;
        xc = xc >>> 16;
        tr = longint'($signed(xr[31:0]));
        tc = longint'($signed(xc[31:0]));
        s = longint'($signed(a_r)) + tr; if (sc) s = s >>> 1; c_r = 32'(s);
        s = longint'($signed(a_c)) + tc; if (sc) s = s >>> 1; c_c = 32'(s);
        s = longint'($signed(a_r)) - tr; if (sc) s = s >>> 1; d_r = 32'(s);
        s = longint'($signed(a_c)) - tc; if (sc) s = s >>> 1; d_c = 32'(s);
    endtask

    task automatic issue(input logic [VW-1:0] a_r, a_c, b_r, b_c, w_r, w_c, input bit sc, iv);
        exp_t e;
        int   g = 0;
        ar = a_r; ac = a_c; br = b_r; bc = b_c; wr = w_r; wc = w_c;
        scale = sc; inv = iv; recv_val = 1'b1;
        for (int i = 0; i < B; i++) begin
            logic [31:0] o_cr, o_cc, o_dr, o_dc;
            lane_model(a_r[i*N +: N], a_c[i*N +: N], b_r[i*N +: N], b_c[i*N +: N],
                       w_r[i*N +: N], w_c[i*N +: N], sc, iv, o_cr, o_cc, o_dr, o_dc);
            e.c_r[i*N +: N] = o_cr; e.c_c[i*N +: N] = o_cc;
            e.d_r[i*N +: N] = o_dr; e.d_c[i*N +: N] = o_dc;
        end
        forever begin
            @(negedge clk);
            if (recv_rdy) begin
                e.acc = cyc;
                q.push_back(e);
                @(posedge clk); #1;
                recv_val = 1'b0;
                return;
            end
            g++;
            if (g > 200) begin
                total++; bad++;
                $display("FAIL accept_timeout actual=no_accept required=accept t=%0t", $time);
                recv_val = 1'b0;
                return;
            end
        end
    endtask

    function automatic logic [VW-1:0] rep(input logic [31:0] x);
        return {B{x}};
    endfunction

    function automatic logic [VW-1:0] rnd();
        logic [VW-1:0] r;
        for (int i = 0; i < B; i++) r[i*N +: N] = $urandom;
        return r;
    endfunction

    task automatic issue_rnd();
        issue(rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    endtask

    task automatic drain();
        int g = 0;
        while (q.size() != 0 && g < 300) begin
            @(posedge clk);
            g++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d_pending required=0", q.size());
        end
        @(posedge clk); #1;
    endtask

    // Monitor: pops on every output transfer; also checks stall behaviour.
    logic [VW-1:0] h_cr, h_cc, h_dr, h_dc;
    bit            prev_stall = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) prev_stall = 1'b0;
        else begin
            if (prev_stall) begin
                check("hold_val", VW'(send_val), VW'(1));
                check("hold_cr", cr, h_cr);
                check("hold_dc", dc, h_dc);
            end
            if (send_val && !send_rdy) check("stall_rdy", VW'(recv_rdy), VW'(0));
            if (send_val && send_rdy) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL extra_output actual=send_val required=none t=%0t", $time);
                end else begin
                    e = q.pop_front();
                    check("cr", cr, e.c_r);
                    check("cc", cc, e.c_c);
                    check("dr", dr, e.d_r);
                    check("dc", dc, e.d_c);
                    if (lat_on) check("latency", VW'(cyc - e.acc), VW'(3));
                end
            end
            prev_stall = send_val && !send_rdy;
            h_cr = cr; h_cc = cc; h_dr = dr; h_dc = dc;
        end
    end

    initial begin
        reset = 1'b1; recv_val = 1'b0; send_rdy = 1'b1;
        ar = '0; ac = '0; br = '0; bc = '0; wr = '0; wc = '0; scale = 1'b0; inv = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_send_val", VW'(send_val), VW'(0));
        check("rst_recv_rdy", VW'(recv_rdy), VW'(0));
        check("rst_cr", cr, '0);
        check("rst_dd", dr | dc | cc, '0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed vectors.
        lat_on = 1'b1;
        issue(rep(32'h0001_0000), '0, rep(32'h0001_0000), '0, rep(32'h0001_0000), '0, 0, 0);
        issue('0, '0, rep(32'h0001_0000), '0, '0, rep(32'h0001_0000), 0, 0);
        issue('0, '0, rep(32'h0001_0000), '0, '0, rep(32'h0001_0000), 0, 1);
        issue(rep(32'h7FFF_0000), '0, rep(32'h0001_0000), '0, rep(32'h0001_0000), '0, 1, 0);
        issue(rep(32'h7FFF_0000), '0, rep(32'h0001_0000), '0, rep(32'h0001_0000), '0, 0, 0);
        issue(rep(32'h8000_0000), rep(32'h8000_0000), rep(32'h8000_0000), rep(32'h8000_0000),
              rep(32'h8000_0000), rep(32'h8000_0000), 0, 1);
        drain();

        // Ten back-to-back with full throughput.
        for (int k = 0; k < 10; k++) issue_rnd();
        drain();

        // Back-to-back with a 5-cycle downstream stall mid-stream.
        lat_on = 1'b0;
        fork
            for (int k = 0; k < 10; k++) issue_rnd();
            begin
                repeat (4) @(posedge clk);
                stall_cnt = 5;
            end
        join
        drain();

        // Random traffic with random backpressure.
        rdy_mode = 1;
        for (int k = 0; k < 60; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            issue_rnd();
        end
        rdy_mode = 0;
        drain();

        // Reset with three transactions in flight.
        lat_on = 1'b1;
        for (int k = 0; k < 3; k++) issue_rnd();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_send_val", VW'(send_val), VW'(0));
        check("midrst_recv_rdy", VW'(recv_rdy), VW'(0));
        check("midrst_out", cr | cc | dr | dc, '0);
        q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        issue(rep(32'h0001_0000), '0, rep(32'h0001_0000), '0, rep(32'h0001_0000), '0, 0, 0);
        drain();
        repeat (5) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
